fifo_ctrl: RTL and testbench

//  Control path for the FIFO; pairs with fifo_register_file (storage). Owns the

---
 rtl/fifo_ctrl.sv | 78 +++++++
 tb/tb_fifo_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// FIFO control path: write/read pointers, occupancy count and status flags for a register-file FIFO.
// w_en is combinational from wr/rd and registered state; all flags are registered and change on the same edge as count.
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic                wr_ok;
    logic                rd_ok;
    logic [ADDR_WIDTH:0] count_nxt;

    // A write into a full FIFO is allowed when a read frees the head cell on the same edge.
    assign wr_ok = wr & (~full | rd);
    assign rd_ok = rd & ~empty;
    assign w_en  = wr_ok;

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr       <= '0;
            r_addr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_addr <= w_addr + PTR_ONE;
            end
            if (rd_ok) begin
                r_addr <= r_addr + PTR_ONE;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= wr & ~wr_ok;
            underflow    <= rd & ~rd_ok;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic       rd;
    logic       w_en;
    logic [2:0] w_addr;
    logic [2:0] r_addr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    // Bench-side register file plus a scoreboard of words in write order.
    logic [7:0] mem [8];
    logic [7:0] sb [$];

    logic [2:0] m_wa;
    logic [2:0] m_ra;
    int         m_cnt;
    logic       m_ov;
    logic       m_un;

    fifo_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .w_en         (w_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wa  = '0;
        m_ra  = '0;
        m_cnt = 0;
        m_ov  = 1'b0;
        m_un  = 1'b0;
        sb.delete();
    endtask

    task automatic check_state();
        chk("w_addr", 32'(w_addr), 32'(m_wa));
        chk("r_addr", 32'(r_addr), 32'(m_ra));
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == 8));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("almost_full", 32'(almost_full), 32'(m_cnt >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 1));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
    endtask

    // Called at posedge+1; drives one request cycle and checks the result after the next edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        logic       e_wok;
        logic       e_rok;
        logic [7:0] e_dat;
        wr = w;
        rd = r;
        #1;
        e_wok = w & ((m_cnt != 8) | r);
        e_rok = r & (m_cnt != 0);
        chk("w_en", 32'(w_en), 32'(e_wok));
        if (e_rok) begin
            e_dat = sb.pop_front();
            chk("rd_data", 32'(mem[r_addr]), 32'(e_dat));
        end
        if (e_wok) begin
            mem[w_addr] = d;
            sb.push_back(d);
        end
        m_wa  = m_wa + 3'(e_wok);
        m_ra  = m_ra + 3'(e_rok);
        m_cnt = m_cnt + int'(e_wok) - int'(e_rok);
        m_ov  = w & ~e_wok;
        m_un  = r & ~e_rok;
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        model_reset();
        #12;
        check_state();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill to full, then one rejected write.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h10 + 8'(i));
        cycle(1'b1, 1'b0, 8'hEE);
        cycle(1'b0, 1'b0, 8'h00);

        // Drain, then reject a read and a read-with-write on empty.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h40);

        // Refill to full and run simultaneous read/write while full.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'h50 + 8'(i));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h60 + 8'(i));

        // Drain to 3 and stream write/read pairs around the wrap point.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'h80 + 8'(i));

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Bring occupancy to 5 and reset asynchronously mid-cycle.
        for (int i = 0; i < 9; i++) begin
            if (m_cnt != 0) cycle(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i));
        wr = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_r_addr", 32'(r_addr), 32'd0);
        model_reset();
        wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_state();
        cycle(1'b1, 1'b0, 8'hC5);
        chk("post_rst_cell0", 32'(mem[0]), 32'hC5);
        cycle(1'b0, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
